// File: rtl/dma_mem_responder_pkg.sv
// Shared constants, types and helpers for the DMA memory responder.
package dma_mem_responder_pkg;

    localparam int unsigned DEF_AXI_AWIDTH     = 32;
    localparam int unsigned DEF_AXI_DWIDTH     = 32;
    localparam int unsigned DEF_MEM_DEPTH_LOG2 = 12;
    localparam int unsigned LEN_W              = 32;
    localparam int unsigned BEATS_W            = LEN_W + 1;
    localparam int unsigned SIZE_W             = 3;
    localparam int unsigned BURST_W            = 2;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [SIZE_W-1:0]  SIZE_4B     = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Side that wins the next tie in IDLE
    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

    // Control part of a burst request (address handled separately: its width is a parameter)
    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } req_ctl_t;

    // Requests we serve anyway but flag: non-4-byte beats and WRAP bursts
    function automatic logic burst_illegal(input logic [SIZE_W-1:0] size,
                                           input logic [BURST_W-1:0] burst);
        return (size != SIZE_4B) || (burst == BURST_WRAP);
    endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// Request/data bus between the DMA controller (master) and the memory responder (slave).
//  read side : request valid/ready + addr/len/size/burst, data/valid/ready back to master
//  write side: request valid/ready + addr/len/size/burst, data/valid from master, ready back
interface dma_mem_responder_if
    import dma_mem_responder_pkg::*;
#(
    parameter int unsigned AW = DEF_AXI_AWIDTH,
    parameter int unsigned DW = DEF_AXI_DWIDTH
);
    logic               dma_read_request_valid;
    logic               dma_read_request_ready;
    logic [AW-1:0]      dma_read_addr;
    logic [LEN_W-1:0]   dma_read_len;
    logic [SIZE_W-1:0]  dma_read_size;
    logic [BURST_W-1:0] dma_read_burst;
    logic [DW-1:0]      dma_read_data;
    logic               dma_read_data_valid;
    logic               dma_read_data_ready;

    logic               dma_write_request_valid;
    logic               dma_write_request_ready;
    logic [AW-1:0]      dma_write_addr;
    logic [LEN_W-1:0]   dma_write_len;
    logic [SIZE_W-1:0]  dma_write_size;
    logic [BURST_W-1:0] dma_write_burst;
    logic [DW-1:0]      dma_write_data;
    logic               dma_write_data_valid;
    logic               dma_write_data_ready;

    modport master (
        output dma_read_request_valid, dma_read_addr, dma_read_len, dma_read_size,
               dma_read_burst, dma_read_data_ready,
               dma_write_request_valid, dma_write_addr, dma_write_len, dma_write_size,
               dma_write_burst, dma_write_data, dma_write_data_valid,
        input  dma_read_request_ready, dma_read_data, dma_read_data_valid,
               dma_write_request_ready, dma_write_data_ready
    );

    modport slave (
        input  dma_read_request_valid, dma_read_addr, dma_read_len, dma_read_size,
               dma_read_burst, dma_read_data_ready,
               dma_write_request_valid, dma_write_addr, dma_write_len, dma_write_size,
               dma_write_burst, dma_write_data, dma_write_data_valid,
        output dma_read_request_ready, dma_read_data, dma_read_data_valid,
               dma_write_request_ready, dma_write_data_ready
    );

endinterface

// File: rtl/dma_resp_ram.sv
// Single-port word RAM with synchronous read; read data holds while en_i is low.
//  clk     : clock
//  en_i    : access enable
//  we_i    : write (when en_i), full-word
//  addr_i  : word index
//  wdata_i : write word
//  rdata_o : read word, valid the cycle after a read access
module dma_resp_ram
    import dma_mem_responder_pkg::*;
#(
    parameter int unsigned DW      = DEF_AXI_DWIDTH,
    parameter int unsigned AW_LOG2 = DEF_MEM_DEPTH_LOG2
) (
    input  logic               clk,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [AW_LOG2-1:0] addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << AW_LOG2;

    logic [DW-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/dma_mem_responder.sv
// DMA-side memory responder: arbitrates read/write burst requests and serves them from a local RAM.
//  clk, resetn : clock, async active-low reset
//  bus         : request/data bus (slave side)
//  busy        : a burst is in progress
//  err         : sticky flag, an illegal size or WRAP burst was accepted
module dma_mem_responder
    import dma_mem_responder_pkg::*;
#(
    parameter int unsigned AXI_AWIDTH     = DEF_AXI_AWIDTH,
    parameter int unsigned AXI_DWIDTH     = DEF_AXI_DWIDTH,
    parameter int unsigned MEM_DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2
) (
    input  logic               clk,
    input  logic               resetn,
    dma_mem_responder_if.slave bus,
    output logic               busy,
    output logic               err
);

    state_e                    state_q, state_d;
    prio_e                     prio_q, prio_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d, idx_adv_c;
    logic [BEATS_W-1:0]        beats_q, beats_d;
    logic [BEATS_W-1:0]        issued_q, issued_d;
    logic [BEATS_W-1:0]        fired_q, fired_d;
    logic                      fixed_q, fixed_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      err_q, err_d;

    logic                      grant_wr_c, grant_rd_c;
    logic                      wr_req_fire_c, rd_req_fire_c;
    logic                      wr_data_fire_c, rd_data_fire_c;
    logic                      rd_en_c, ram_en_c;
    logic [AXI_AWIDTH-1:0]     req_addr_c;
    req_ctl_t                  req_c;
    logic [AXI_DWIDTH-1:0]     ram_rdata;
    logic                      unused_addr_bits_c;

    // Tie-break: write wins unless the last served side was a write
    assign grant_wr_c = bus.dma_write_request_valid &
                        (~bus.dma_read_request_valid | (prio_q == PRIO_WRITE));
    assign grant_rd_c = bus.dma_read_request_valid & ~grant_wr_c;

    assign bus.dma_write_request_ready = (state_q == ST_IDLE) & grant_wr_c;
    assign bus.dma_read_request_ready  = (state_q == ST_IDLE) & grant_rd_c;
    assign bus.dma_write_data_ready    = (state_q == ST_WRITE);
    assign bus.dma_read_data_valid     = rd_valid_q;
    assign bus.dma_read_data           = ram_rdata;
    assign busy                        = (state_q != ST_IDLE);
    assign err                         = err_q;

    assign wr_req_fire_c  = bus.dma_write_request_ready;
    assign rd_req_fire_c  = bus.dma_read_request_ready;
    assign wr_data_fire_c = bus.dma_write_data_ready & bus.dma_write_data_valid;
    assign rd_data_fire_c = rd_valid_q & bus.dma_read_data_ready;

    // Issue a RAM read when beats remain and the output slot is free or being drained
    assign rd_en_c  = (state_q == ST_READ) & (issued_q < beats_q) & (~rd_valid_q | rd_data_fire_c);
    assign ram_en_c = rd_en_c | wr_data_fire_c;

    assign idx_adv_c = fixed_q ? idx_q : idx_q + MEM_DEPTH_LOG2'(1);

    // Payload of whichever side is granted
    always_comb begin
        if (grant_wr_c) begin
            req_addr_c  = bus.dma_write_addr;
            req_c.len   = bus.dma_write_len;
            req_c.size  = bus.dma_write_size;
            req_c.burst = bus.dma_write_burst;
        end else begin
            req_addr_c  = bus.dma_read_addr;
            req_c.len   = bus.dma_read_len;
            req_c.size  = bus.dma_read_size;
            req_c.burst = bus.dma_read_burst;
        end
    end

    // Byte-lane bits and bits above the RAM depth do not select a word
    assign unused_addr_bits_c = ^{req_addr_c[1:0], req_addr_c[AXI_AWIDTH-1:MEM_DEPTH_LOG2+2]};

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        idx_d      = idx_q;
        beats_d    = beats_q;
        issued_d   = issued_q;
        fired_d    = fired_q;
        fixed_d    = fixed_q;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_req_fire_c | rd_req_fire_c) begin
                    idx_d    = req_addr_c[MEM_DEPTH_LOG2+1:2];
                    beats_d  = BEATS_W'(req_c.len) + BEATS_W'(1);
                    issued_d = '0;
                    fired_d  = '0;
                    fixed_d  = (req_c.burst == BURST_FIXED);
                    err_d    = err_q | burst_illegal(req_c.size, req_c.burst);
                    state_d  = wr_req_fire_c ? ST_WRITE : ST_READ;
                    prio_d   = wr_req_fire_c ? PRIO_READ : PRIO_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_data_fire_c) begin
                    idx_d   = idx_adv_c;
                    fired_d = fired_q + BEATS_W'(1);
                    if (fired_q + BEATS_W'(1) == beats_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (rd_en_c) begin
                    idx_d    = idx_adv_c;
                    issued_d = issued_q + BEATS_W'(1);
                end
                rd_valid_d = rd_en_c ? 1'b1 : (rd_data_fire_c ? 1'b0 : rd_valid_q);
                if (rd_data_fire_c) begin
                    fired_d = fired_q + BEATS_W'(1);
                    if (fired_q + BEATS_W'(1) == beats_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            prio_q     <= PRIO_WRITE;
            idx_q      <= '0;
            beats_q    <= '0;
            issued_q   <= '0;
            fired_q    <= '0;
            fixed_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            idx_q      <= idx_d;
            beats_q    <= beats_d;
            issued_q   <= issued_d;
            fired_q    <= fired_d;
            fixed_q    <= fixed_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    dma_resp_ram #(
        .DW      (AXI_DWIDTH),
        .AW_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (wr_data_fire_c),
        .addr_i  (idx_q),
        .wdata_i (bus.dma_write_data),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_dma_mem_responder.sv
// Self-checking bench for dma_mem_responder: directed table, hand-written corner sequences,
// and random bursts against a word-array memory model.
module tb_dma_mem_responder;
    import dma_mem_responder_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DL    = 12;
    localparam int unsigned DEPTH = 4096;

    logic clk;
    logic resetn;
    logic busy;
    logic err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    bit          err_m;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] dbase;
        int          mode;
        logic [31:0] exp_last;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    dma_mem_responder_if #(.AW(AW), .DW(DW)) bus();

    dma_mem_responder #(
        .AXI_AWIDTH     (AW),
        .AXI_DWIDTH     (DW),
        .MEM_DEPTH_LOG2 (DL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word index of beat i of a burst: 4-byte words, FIXED stays put, anything else increments mod depth
    function automatic logic [11:0] widx(input logic [31:0] addr, input int unsigned i,
                                          input logic [1:0] burst);
        logic [31:0] base;
        base = addr >> 2;
        if (burst == BURST_FIXED) return 12'(base % DEPTH);
        return 12'((base + i) % DEPTH);
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.dma_write_request_ready;
            1:       return bus.dma_write_data_ready;
            2:       return bus.dma_read_request_ready;
            default: return bus.dma_read_data_valid;
        endcase
    endfunction

    // Called right after driving at a negedge; returns #1 after the negedge where the signal is high
    task automatic wait_hi(input string name, input int which);
        int n;
        n = 0;
        #1;
        while (!sig(which) && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!sig(which)) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout, got 0 expected 1", name);
        end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [31:0] dbase, input bit rnd);
        logic [31:0] d;
        @(negedge clk);
        bus.dma_write_addr          = addr;
        bus.dma_write_len           = len;
        bus.dma_write_size          = size;
        bus.dma_write_burst         = burst;
        bus.dma_write_request_valid = 1'b1;
        wait_hi("wr_req", 0);
        @(negedge clk);
        bus.dma_write_request_valid = 1'b0;
        if (size != 3'd2 || burst == BURST_WRAP) err_m = 1'b1;
        for (int unsigned i = 0; i <= len; i++) begin
            if (rnd && $urandom_range(3) == 0) @(negedge clk);
            d = rnd ? $urandom : dbase + i;
            bus.dma_write_data       = d;
            bus.dma_write_data_valid = 1'b1;
            wait_hi("wr_data", 1);
            mem_m[widx(addr, i, burst)] = d;
            @(negedge clk);
            bus.dma_write_data_valid = 1'b0;
        end
    endtask

    // mode 0: ready always high (latency/throughput checked), 1: ready 1,0,0,..., 2: random
    task automatic rd_burst(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode, output logic [31:0] last);
        int unsigned k;
        int          cyc;
        logic        r;
        k    = 0;
        cyc  = 0;
        last = 'x;
        @(negedge clk);
        bus.dma_read_addr          = addr;
        bus.dma_read_len           = len;
        bus.dma_read_size          = size;
        bus.dma_read_burst         = burst;
        bus.dma_read_request_valid = 1'b1;
        wait_hi("rd_req", 2);
        @(negedge clk);
        bus.dma_read_request_valid = 1'b0;
        if (size != 3'd2 || burst == BURST_WRAP) err_m = 1'b1;
        while (k <= len && cyc < 200) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
            bus.dma_read_data_ready = r;
            #1;
            if (mode == 0 && k > 0) chk("rd_valid_streak", bus.dma_read_data_valid, 1);
            if (bus.dma_read_data_valid) begin
                if (k == 0 && mode == 0) chk("rd_first_latency", cyc, 1);
                chk("rd_data", bus.dma_read_data, mem_m[widx(addr, k, burst)]);
                if (r) begin
                    last = bus.dma_read_data;
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.dma_read_data_ready = 1'b0;
        if (k <= len) begin
            checks++;
            failures++;
            $display("FAIL rd_beats: got %0d beats expected %0d", k, len + 1);
        end
        #1;
        chk("rd_busy_after", busy, 0);
        chk("rd_valid_after", bus.dma_read_data_valid, 0);
    endtask

    // Present a tie, check the grant, then withdraw both before anything fires
    task automatic tie_probe(input bit exp_wr);
        @(negedge clk);
        bus.dma_write_addr          = 32'h700;
        bus.dma_write_len           = 32'd0;
        bus.dma_read_addr           = 32'h700;
        bus.dma_read_len            = 32'd0;
        bus.dma_write_request_valid = 1'b1;
        bus.dma_read_request_valid  = 1'b1;
        #1;
        chk("tie_wr_ready", bus.dma_write_request_ready, exp_wr);
        chk("tie_rd_ready", bus.dma_read_request_ready, !exp_wr);
        bus.dma_write_request_valid = 1'b0;
        bus.dma_read_request_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] addr;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  burst;

        tbl[0]  = '{1'b1, 32'h100,  32'd3, 3'd2, BURST_INCR,  32'd1,    0, 32'h0,  1'b0};
        tbl[1]  = '{1'b0, 32'h100,  32'd3, 3'd2, BURST_INCR,  32'd0,    0, 32'h4,  1'b0};
        tbl[2]  = '{1'b1, 32'h200,  32'd7, 3'd2, BURST_INCR,  32'h10,   0, 32'h0,  1'b0};
        tbl[3]  = '{1'b0, 32'h200,  32'd7, 3'd2, BURST_INCR,  32'd0,    1, 32'h17, 1'b0};
        tbl[4]  = '{1'b1, 32'h40,   32'd2, 3'd2, BURST_FIXED, 32'hA,    0, 32'h0,  1'b0};
        tbl[5]  = '{1'b0, 32'h40,   32'd0, 3'd2, BURST_INCR,  32'd0,    0, 32'hC,  1'b0};
        tbl[6]  = '{1'b1, 32'h3FFC, 32'd1, 3'd2, BURST_INCR,  32'h55,   0, 32'h0,  1'b0};
        tbl[7]  = '{1'b0, 32'h3FFC, 32'd1, 3'd2, BURST_INCR,  32'd0,    2, 32'h56, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,    32'd0, 3'd2, BURST_INCR,  32'd0,    0, 32'h56, 1'b0};
        tbl[9]  = '{1'b0, 32'h100,  32'd3, 3'd2, BURST_WRAP,  32'd0,    0, 32'h4,  1'b1};
        tbl[10] = '{1'b1, 32'h500,  32'd1, 3'd3, BURST_INCR,  32'h77,   0, 32'h0,  1'b1};
        tbl[11] = '{1'b0, 32'h500,  32'd1, 3'd2, BURST_INCR,  32'd0,    0, 32'h78, 1'b1};

        bus.dma_read_request_valid  = 1'b0;
        bus.dma_read_addr           = '0;
        bus.dma_read_len            = '0;
        bus.dma_read_size           = 3'd2;
        bus.dma_read_burst          = BURST_INCR;
        bus.dma_read_data_ready     = 1'b0;
        bus.dma_write_request_valid = 1'b0;
        bus.dma_write_addr          = '0;
        bus.dma_write_len           = '0;
        bus.dma_write_size          = 3'd2;
        bus.dma_write_burst         = BURST_INCR;
        bus.dma_write_data          = '0;
        bus.dma_write_data_valid    = 1'b0;
        err_m  = 1'b0;
        resetn = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", bus.dma_read_data_valid, 0);
        chk("rst_wr_data_ready", bus.dma_write_data_ready, 0);
        chk("rst_wr_req_ready", bus.dma_write_request_ready, 0);
        chk("rst_rd_req_ready", bus.dma_read_request_ready, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Give every RAM word a known value
        wr_burst(32'h0, 32'(DEPTH - 1), 3'd2, BURST_INCR, 32'd0, 1'b1);

        for (int v = 0; v < 12; v++) begin
            if (tbl[v].wr) begin
                wr_burst(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, tbl[v].dbase, 1'b0);
            end else begin
                rd_burst(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, tbl[v].mode, last);
                chk($sformatf("tbl%0d_last", v), last, tbl[v].exp_last);
            end
            chk($sformatf("tbl%0d_err", v), err, tbl[v].exp_err);
        end

        for (int t = 0; t < 40; t++) begin
            addr  = $urandom_range(32'h7FFF);
            len   = $urandom_range(5);
            burst = 2'($urandom_range(2));
            size  = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'd2;
            if ($urandom_range(1) == 1) wr_burst(addr, len, size, burst, 32'd0, 1'b1);
            else                        rd_burst(addr, len, size, burst, 2, last);
            chk("rand_err", err, err_m);
        end

        // Reset in the middle of an 8-beat read
        @(negedge clk);
        bus.dma_read_addr          = 32'h200;
        bus.dma_read_len           = 32'd7;
        bus.dma_read_size          = 3'd2;
        bus.dma_read_burst         = BURST_INCR;
        bus.dma_read_request_valid = 1'b1;
        wait_hi("midrst_req", 2);
        @(negedge clk);
        bus.dma_read_request_valid = 1'b0;
        bus.dma_read_data_ready    = 1'b1;
        wait_hi("midrst_beat", 3);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_beat2", bus.dma_read_data, mem_m[widx(32'h200, 2, BURST_INCR)]);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", bus.dma_read_data_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        err_m = 1'b0;
        bus.dma_read_data_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rd_burst(32'h200, 32'd7, 3'd2, BURST_INCR, 0, last);
        chk("postrst_last", last, 32'h17);

        // Tie right after reset: write first, read stays pending and is granted afterwards
        @(negedge clk);
        bus.dma_write_addr          = 32'h600;
        bus.dma_write_len           = 32'd0;
        bus.dma_write_size          = 3'd2;
        bus.dma_write_burst         = BURST_INCR;
        bus.dma_read_addr           = 32'h600;
        bus.dma_read_len            = 32'd0;
        bus.dma_read_size           = 3'd2;
        bus.dma_read_burst          = BURST_INCR;
        bus.dma_write_data          = 32'hDEAD0001;
        bus.dma_write_data_valid    = 1'b1;
        bus.dma_write_request_valid = 1'b1;
        bus.dma_read_request_valid  = 1'b1;
        bus.dma_read_data_ready     = 1'b1;
        #1;
        chk("arb_rst_wr_ready", bus.dma_write_request_ready, 1);
        chk("arb_rst_rd_ready", bus.dma_read_request_ready, 0);
        @(negedge clk);
        bus.dma_write_request_valid = 1'b0;
        #1;
        chk("arb_wr_data_ready", bus.dma_write_data_ready, 1);
        chk("arb_rd_pending", bus.dma_read_request_ready, 0);
        chk("arb_busy", busy, 1);
        mem_m[widx(32'h600, 0, BURST_INCR)] = 32'hDEAD0001;
        @(negedge clk);
        bus.dma_write_data_valid = 1'b0;
        #1;
        chk("arb_rd_grant", bus.dma_read_request_ready, 1);
        chk("arb_wr_no_grant", bus.dma_write_request_ready, 0);
        @(negedge clk);
        bus.dma_read_request_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("arb_rd_valid", bus.dma_read_data_valid, 1);
        chk("arb_rd_data", bus.dma_read_data, 32'hDEAD0001);
        @(negedge clk);
        bus.dma_read_data_ready = 1'b0;
        #1;
        chk("arb_idle", busy, 0);

        tie_probe(1'b1);
        rd_burst(32'h600, 32'd0, 3'd2, BURST_INCR, 0, last);
        tie_probe(1'b1);
        wr_burst(32'h604, 32'd0, 3'd2, BURST_INCR, 32'h1234, 1'b0);
        tie_probe(1'b0);
        rd_burst(32'h604, 32'd0, 3'd2, BURST_INCR, 0, last);
        chk("arb_final_last", last, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
